// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller:
// FSM states, power-up command list and the clear/home decode.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_EN,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  localparam int         INIT_LEN      = 4;
  localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

  // 8-bit bus, 2 lines, display on, clear, entry mode increment
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] dat);
    return !rs && ((dat & CLR_HOME_MASK) == 8'h00);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with zero flag; one-cycle load, holds at zero.
// Shared by every timed state of the LCD controller, no backpressure.
module lcd_delay_cnt #(
  parameter int            CW      = 8,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_char_ctrl.sv
// Write-only HD44780 controller: power-up init, RS/EN/DATA pin timing, execution waits.
// Requests accepted only in IDLE (o_req_rdy); ready returns SETUP+EN+HOLD+WAIT cycles later.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 3,
  parameter int T_EN_HI = 25,
  parameter int T_HOLD  = 3,
  parameter int T_CMD   = 2500,
  parameter int T_CLEAR = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_rdy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int T_MAX = max_i(max_i(max_i(T_PWRUP, T_SETUP), max_i(T_EN_HI, T_HOLD)),
                               max_i(T_CMD, T_CLEAR));
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_HI - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);
  localparam logic [1:0]    IDX_LAST = 2'(INIT_LEN - 1);

  lcd_state_e    state_q;
  logic [1:0]    idx_q;
  logic          en_q, rs_q, rdy_q, done_q, on_q;
  logic [7:0]    data_q;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          more_init;

  assign more_init = !done_q && (idx_q != IDX_LAST);

  // Counter reloads on every state entry; PWRUP entry is the reset value itself.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_PWRUP: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = LD_SETUP; end
      ST_SETUP: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = LD_EN; end
      ST_EN:    if (cnt_zero) begin cnt_load = 1'b1; cnt_val = LD_HOLD; end
      ST_HOLD:  if (cnt_zero) begin
                  cnt_load = 1'b1;
                  cnt_val  = is_slow_cmd(rs_q, data_q) ? LD_CLEAR : LD_CMD;
                end
      ST_WAIT:  if (cnt_zero && more_init) begin cnt_load = 1'b1; cnt_val = LD_SETUP; end
      ST_IDLE:  if (i_req_vld && rdy_q) begin cnt_load = 1'b1; cnt_val = LD_SETUP; end
      default:  begin cnt_load = 1'b0; cnt_val = '0; end
    endcase
  end

  lcd_delay_cnt #(
    .CW      (CW),
    .RST_VAL (LD_PWRUP)
  ) u_delay_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .o_zero     (cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_PWRUP;
      idx_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      on_q <= 1'b1;
      unique case (state_q)
        ST_PWRUP: if (cnt_zero) begin
          state_q <= ST_SETUP;
          idx_q   <= '0;
          rs_q    <= 1'b0;
          data_q  <= init_cmd(2'd0);
        end
        ST_SETUP: if (cnt_zero) begin
          state_q <= ST_EN;
          en_q    <= 1'b1;
        end
        ST_EN: if (cnt_zero) begin
          state_q <= ST_HOLD;
          en_q    <= 1'b0;
        end
        ST_HOLD: if (cnt_zero) begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (cnt_zero) begin
          if (more_init) begin
            state_q <= ST_SETUP;
            idx_q   <= idx_q + 2'd1;
            rs_q    <= 1'b0;
            data_q  <= init_cmd(idx_q + 2'd1);
          end else begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            rdy_q   <= 1'b1;
          end
        end
        ST_IDLE: if (i_req_vld && rdy_q) begin
          state_q <= ST_SETUP;
          rs_q    <= i_req_rs;
          data_q  <= i_req_data;
          rdy_q   <= 1'b0;
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  assign o_req_rdy   = rdy_q;
  assign o_init_done = done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: transaction-timeline model compared every cycle,
// directed literal timing checks, randomized request traffic and mid-strobe reset.
module tb_lcd_char_ctrl;

  localparam int TP = 20, TS = 2, TE = 4, TH = 2, TC = 10, TCL = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       o_req_rdy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  int n_chk = 0;
  int n_fail = 0;

  lcd_char_ctrl #(
    .T_PWRUP (TP), .T_SETUP (TS), .T_EN_HI (TE),
    .T_HOLD  (TH), .T_CMD   (TC), .T_CLEAR (TCL)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_vld   (vld),
    .i_req_rs    (rs),
    .i_req_data  (data),
    .o_req_rdy   (o_req_rdy),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_data  (o_lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_init(input int i);
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    return cmds[i];
  endfunction

  // Model: each transaction is a start edge plus a total length; pins follow from elapsed edges.
  int         mk = 0, mt0 = 0, mtw = 0, midx = 0;
  bit         mstarted = 0, mrdy = 0, mdone = 0, mon = 0, men = 0, mrs = 0;
  logic [7:0] mdata = 8'h00;

  function automatic int wait_len(input bit r, input logic [7:0] d);
    return (!r && d < 8'd4) ? TCL : TC;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0; mt0 = 0; mtw = 0; midx = 0;
      mstarted = 0; mrdy = 0; mdone = 0; mon = 0; men = 0; mrs = 0; mdata = 8'h00;
    end else begin
      mk++;
      mon = 1;
      if (!mstarted) begin
        if (mk == TP) begin
          mstarted = 1; mt0 = mk; mrs = 0; mdata = ref_init(0); mtw = wait_len(0, mdata);
        end
      end else if (mrdy) begin
        if (vld) begin
          mrdy = 0; mt0 = mk; mrs = rs; mdata = data; mtw = wait_len(rs, data);
        end
      end else if (mk - mt0 == TS + TE + TH + mtw) begin
        if (!mdone && midx < 3) begin
          midx++; mt0 = mk; mrs = 0; mdata = ref_init(midx); mtw = wait_len(0, mdata);
        end else begin
          mdone = 1; mrdy = 1;
        end
      end
      men = mstarted && !mrdy && (mk - mt0 >= TS) && (mk - mt0 < TS + TE);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("lcd_en",    {31'd0, o_lcd_en},    {31'd0, men});
      check("lcd_rs",    {31'd0, o_lcd_rs},    {31'd0, mrs});
      check("lcd_data",  {24'd0, o_lcd_data},  {24'd0, mdata});
      check("req_rdy",   {31'd0, o_req_rdy},   {31'd0, mrdy});
      check("init_done", {31'd0, o_init_done}, {31'd0, mdone});
      check("lcd_on",    {31'd0, o_lcd_on},    {31'd0, mon});
      check("lcd_rw",    {31'd0, o_lcd_rw},    32'd0);
    end
  end

  // Presents a request and returns once the accepting edge has occurred.
  task automatic send(input logic r, input logic [7:0] d, input bit hold, output int w);
    @(negedge clk);
    vld = 1'b1; rs = r; data = d; w = 0;
    while (!o_req_rdy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!o_req_rdy) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      vld = 1'b0;
    end
  endtask

  task automatic cnt_to_rdy(output int n, output int en_n, output int en_first);
    n = 0; en_n = 0; en_first = -1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (o_lcd_en) begin
        en_n++;
        if (en_first < 0) en_first = n;
      end
    end while (!o_req_rdy && n < 1000);
  endtask

  initial begin
    int w, n, en_n, en_first;

    repeat (3) @(negedge clk);
    check("rst_en",   {31'd0, o_lcd_en},    32'd0);
    check("rst_rdy",  {31'd0, o_req_rdy},   32'd0);
    check("rst_done", {31'd0, o_init_done}, 32'd0);
    check("rst_on",   {31'd0, o_lcd_on},    32'd0);
    check("rst_data", {24'd0, o_lcd_data},  32'd0);
    rst_n = 1'b1;

    cnt_to_rdy(n, en_n, en_first);
    check("init_cycles",   n,        32'd112);
    check("init_en_cyc",   en_n,     32'd16);
    check("init_en_first", en_first, 32'd22);
    check("init_done",     {31'd0, o_init_done}, 32'd1);

    send(1'b1, 8'h41, 1'b0, w);
    cnt_to_rdy(n, en_n, en_first);
    check("dat41_cycles",   n,        32'd18);
    check("dat41_en_cyc",   en_n,     32'd4);
    check("dat41_en_first", en_first, 32'd2);

    send(1'b0, 8'h01, 1'b0, w);
    cnt_to_rdy(n, en_n, en_first);
    check("clear_cycles", n, 32'd38);
    send(1'b0, 8'h02, 1'b0, w);
    cnt_to_rdy(n, en_n, en_first);
    check("home_cycles", n, 32'd38);
    send(1'b0, 8'h80, 1'b0, w);
    cnt_to_rdy(n, en_n, en_first);
    check("ddram_cycles", n, 32'd18);

    send(1'b1, 8'h41, 1'b1, w);
    send(1'b1, 8'h42, 1'b0, w);
    check("busy_hold_wait", w, 32'd18);
    cnt_to_rdy(n, en_n, en_first);
    check("dat42_cycles", n, 32'd18);

    repeat (1500) begin
      @(negedge clk);
      vld  = ($urandom_range(0, 2) == 0);
      rs   = 1'($urandom_range(0, 1));
      data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    vld = 1'b0;
    n = 0;
    while (!o_req_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rand_drain", {31'd0, o_req_rdy}, 32'd1);

    send(1'b1, 8'h5A, 1'b0, w);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_lcd_en && n < 100);
    check("pre_rst_en", {31'd0, o_lcd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_en",   {31'd0, o_lcd_en},    32'd0);
    check("arst_data", {24'd0, o_lcd_data},  32'd0);
    check("arst_done", {31'd0, o_init_done}, 32'd0);
    check("arst_rdy",  {31'd0, o_req_rdy},   32'd0);
    check("arst_on",   {31'd0, o_lcd_on},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(1'b1, 8'h33, 1'b0, w);
    check("init_vld_wait", w, 32'd111);
    cnt_to_rdy(n, en_n, en_first);
    check("post_rst_cycles", n, 32'd18);
    check("post_rst_done",   {31'd0, o_init_done}, 32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
